// File: rtl/audio_mixer_pkg.sv
// Shared types and constants for the Genesis audio mixer: FSM encoding,
// accumulator width, 16-bit saturation limits and the unity-gain shift.
package audio_mixer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_MUL_FML,
        ST_MUL_FMR,
        ST_MUL_PSG,
        ST_LPF,
        ST_COMMIT
    } state_t;

    localparam int ACC_W      = 20;
    localparam int MUL_W      = 18;
    localparam int GAIN_SHIFT = 3;

    localparam logic signed [ACC_W-1:0] SAT16_MAX = 20'sd32767;
    localparam logic signed [ACC_W-1:0] SAT16_MIN = -20'sd32768;

endpackage

// File: rtl/mix_sat16.sv
// Combinational 20-bit to 16-bit signed saturator; clip is high whenever
// the input lies outside the 16-bit signed range.
module mix_sat16
    import audio_mixer_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [15:0]      sat,
    output logic                    clip
);

    always_comb begin
        sat  = acc[15:0];
        clip = 1'b0;
        if (acc > SAT16_MAX) begin
            sat  = 16'sh7FFF;
            clip = 1'b1;
        end else if (acc < SAT16_MIN) begin
            sat  = 16'sh8000;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/audio_mixer.sv
// Genesis FM + PSG stereo mixer with one time-shared 18x5 multiplier.
// Define AUDIO_MIXER_LPF_EN to add a one-pole low-pass per channel (one extra cycle).
module audio_mixer
    import audio_mixer_pkg::*;
#(
    parameter int FM_W  = 14,
    parameter int PSG_W = 8
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic signed [FM_W-1:0]  iFM_L,
    input  logic signed [FM_W-1:0]  iFM_R,
    input  logic                    iFM_STB,
    input  logic [PSG_W-1:0]        iPSG,
    input  logic                    iPSG_STB,
    input  logic [3:0]              iFM_VOL,
    input  logic [3:0]              iPSG_VOL,
    input  logic                    iMUTE,
    output logic signed [15:0]      oSL,
    output logic signed [15:0]      oSR,
    output logic                    oSTB,
    output logic                    oCLIP
);

    localparam logic [MUL_W-1:0] PSG_MID = MUL_W'(1) << (PSG_W-1);

    state_t state_reg, state_next;
    logic   pending_reg;
    logic   any_stb;
    logic   snap_en, mul_en, commit_en;
    logic [1:0] mul_sel;

    logic signed [FM_W-1:0]   fm_hold_reg [2];
    logic signed [FM_W-1:0]   fm_op_reg   [2];
    logic [PSG_W-1:0]         psg_hold_reg, psg_op_reg;
    logic [3:0]               fm_vol_reg, psg_vol_reg;

    logic signed [MUL_W-1:0]  fm_aln [2];
    logic signed [MUL_W-1:0]  psg_aln;
    logic signed [MUL_W-1:0]  mul_a;
    logic [3:0]               mul_b;
    logic signed [MUL_W+4:0]  product;
    logic signed [ACC_W-1:0]  mul_out;
    logic signed [ACC_W-1:0]  prod_fm_reg [2];
    logic signed [ACC_W-1:0]  prod_psg_reg;

    logic signed [15:0]       ch_out      [2];
    logic [1:0]               ch_sat_clip;
    logic                     commit_clip;

    logic signed [15:0]       sl_reg, sr_reg;
    logic                     stb_reg, clip_reg;

    assign any_stb = iFM_STB | iPSG_STB;

    // A strobe landing in SNAP keeps pending set: the snapshot took the old sample.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fm_hold_reg[0] <= '0;
            fm_hold_reg[1] <= '0;
            psg_hold_reg   <= '0;
            pending_reg    <= 1'b0;
        end else begin
            if (iFM_STB) begin
                fm_hold_reg[0] <= iFM_L;
                fm_hold_reg[1] <= iFM_R;
            end
            if (iPSG_STB)
                psg_hold_reg <= iPSG;
            if (any_stb)
                pending_reg <= 1'b1;
            else if (snap_en)
                pending_reg <= 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // IDLE and COMMIT look at the live strobe too, giving 5-cycle latency and spacing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (pending_reg || any_stb) state_next = ST_SNAP;
            ST_SNAP:    state_next = ST_MUL_FML;
            ST_MUL_FML: state_next = ST_MUL_FMR;
            ST_MUL_FMR: state_next = ST_MUL_PSG;
`ifdef AUDIO_MIXER_LPF_EN
            ST_MUL_PSG: state_next = ST_LPF;
`else
            ST_MUL_PSG: state_next = ST_COMMIT;
`endif
            ST_LPF:     state_next = ST_COMMIT;
            ST_COMMIT:  state_next = (pending_reg || any_stb) ? ST_SNAP : ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

`ifdef AUDIO_MIXER_LPF_EN
    logic lpf_en;
`endif

    always_comb begin
        snap_en   = 1'b0;
        mul_en    = 1'b0;
        mul_sel   = 2'd0;
        commit_en = 1'b0;
`ifdef AUDIO_MIXER_LPF_EN
        lpf_en    = (state_reg == ST_LPF);
`endif
        case (state_reg)
            ST_SNAP:    snap_en = 1'b1;
            ST_MUL_FML: begin mul_en = 1'b1; mul_sel = 2'd0; end
            ST_MUL_FMR: begin mul_en = 1'b1; mul_sel = 2'd1; end
            ST_MUL_PSG: begin mul_en = 1'b1; mul_sel = 2'd2; end
            ST_COMMIT:  commit_en = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            fm_op_reg[0] <= '0;
            fm_op_reg[1] <= '0;
            psg_op_reg   <= '0;
            fm_vol_reg   <= '0;
            psg_vol_reg  <= '0;
        end else if (snap_en) begin
            fm_op_reg[0] <= fm_hold_reg[0];
            fm_op_reg[1] <= fm_hold_reg[1];
            psg_op_reg   <= psg_hold_reg;
            fm_vol_reg   <= iFM_VOL;
            psg_vol_reg  <= iPSG_VOL;
        end
    end

    // FM lands at full scale, PSG (offset-binary) at half scale.
    assign psg_aln = (MUL_W'({1'b0, psg_op_reg}) - PSG_MID) << (15-PSG_W);

    always_comb begin
        case (mul_sel)
            2'd0:    begin mul_a = fm_aln[0]; mul_b = fm_vol_reg;  end
            2'd1:    begin mul_a = fm_aln[1]; mul_b = fm_vol_reg;  end
            default: begin mul_a = psg_aln;   mul_b = psg_vol_reg; end
        endcase
    end

    assign product = mul_a * $signed({1'b0, mul_b});
    assign mul_out = ACC_W'(product >>> GAIN_SHIFT);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            prod_fm_reg[0] <= '0;
            prod_fm_reg[1] <= '0;
            prod_psg_reg   <= '0;
        end else if (mul_en) begin
            case (mul_sel)
                2'd0:    prod_fm_reg[0] <= mul_out;
                2'd1:    prod_fm_reg[1] <= mul_out;
                default: prod_psg_reg   <= mul_out;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic signed [ACC_W-1:0] sum;
        logic signed [15:0]      sat;

        assign fm_aln[gi] = MUL_W'(fm_op_reg[gi]) <<< (16-FM_W);
        assign sum        = prod_fm_reg[gi] + prod_psg_reg;

        mix_sat16 u_sat (
            .acc  (sum),
            .sat  (sat),
            .clip (ch_sat_clip[gi])
        );

`ifdef AUDIO_MIXER_LPF_EN
        logic signed [15:0] x_reg, y_reg, y_next;
        logic signed [16:0] x_ext, y_ext, diff, step;

        assign x_ext  = 17'(x_reg);
        assign y_ext  = 17'(y_reg);
        assign diff   = x_ext - y_ext;
        assign step   = diff >>> 2;
        assign y_next = 16'(y_ext + step);

        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                x_reg <= '0;
                y_reg <= '0;
            end else begin
                if (lpf_en)
                    x_reg <= sat;
                if (commit_en && !iMUTE)
                    y_reg <= y_next;
            end
        end

        assign ch_out[gi] = y_next;
`else
        assign ch_out[gi] = sat;
`endif
    end

`ifdef AUDIO_MIXER_LPF_EN
    logic clip_hold_reg;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            clip_hold_reg <= 1'b0;
        else if (lpf_en)
            clip_hold_reg <= |ch_sat_clip;
    end

    assign commit_clip = clip_hold_reg;
`else
    assign commit_clip = |ch_sat_clip;
`endif

    // Both channels change on the same edge so the serializer never sees a half-updated pair.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sl_reg   <= '0;
            sr_reg   <= '0;
            stb_reg  <= 1'b0;
            clip_reg <= 1'b0;
        end else begin
            stb_reg  <= commit_en;
            clip_reg <= commit_en && !iMUTE && commit_clip;
            if (commit_en) begin
                sl_reg <= iMUTE ? 16'sd0 : ch_out[0];
                sr_reg <= iMUTE ? 16'sd0 : ch_out[1];
            end
        end
    end

    assign oSL   = sl_reg;
    assign oSR   = sr_reg;
    assign oSTB  = stb_reg;
    assign oCLIP = clip_reg;

endmodule

// File: tb/tb_audio_mixer.sv
// Directed-vector bench for audio_mixer (default build): hand-computed mixes,
// saturation, mute, back-to-back strobes and reset mid-sequence.
module tb_audio_mixer;
    import audio_mixer_pkg::*;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] fm_l = '0, fm_r = '0;
    logic        fm_stb = 1'b0;
    logic [7:0]  psg = '0;
    logic        psg_stb = 1'b0;
    logic [3:0]  fm_vol = '0, psg_vol = '0;
    logic        mute = 1'b0;
    logic [15:0] sl, sr;
    logic        stb, clip;

    int n_vec = 0;
    int n_err = 0;

    audio_mixer #(.FM_W(14), .PSG_W(8)) dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .iFM_L    (fm_l),
        .iFM_R    (fm_r),
        .iFM_STB  (fm_stb),
        .iPSG     (psg),
        .iPSG_STB (psg_stb),
        .iFM_VOL  (fm_vol),
        .iPSG_VOL (psg_vol),
        .iMUTE    (mute),
        .oSL      (sl),
        .oSR      (sr),
        .oSTB     (stb),
        .oCLIP    (clip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [13:0] l, input logic [13:0] r, input logic [7:0] p,
                        input logic [3:0] fv, input logic [3:0] pv);
        fm_l = l; fm_r = r; psg = p; fm_vol = fv; psg_vol = pv;
    endtask

    task automatic fire(input logic f, input logic p);
        fm_stb = f;
        psg_stb = p;
        tick(1);
        fm_stb = 1'b0;
        psg_stb = 1'b0;
    endtask

    task automatic expect_mix(input string tag, input logic [15:0] el, input logic [15:0] er,
                              input logic ec);
        int n = 0;
        while (stb !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_l"}, sl, el);
        chk({tag, "_r"}, sr, er);
        chk({tag, "_clip"}, clip, ec);
        $display("commit %s: L=0x%h R=0x%h clip=%b after %0d cycles", tag, sl, sr, clip, n);
        tick(1);
        chk({tag, "_stb_off"}, stb, 1'b0);
        chk({tag, "_hold"}, sl, el);
    endtask

    initial begin
        int times[$];
        logic [15:0] last_l;
        int stb_seen;

        tick(3);
        chk("rst_sl", sl, 16'h0);
        chk("rst_sr", sr, 16'h0);
        chk("rst_stb", stb, 1'b0);
        chk("rst_clip", clip, 1'b0);
        chk("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick(2);

        load(14'h1000, 14'h3000, 8'd128, 4'd8, 4'd8);
        fire(1'b1, 1'b1);
        expect_mix("unity", 16'h4000, 16'hC000, 1'b0);

        load(14'h1FFF, 14'h1FFF, 8'd255, 4'd15, 4'd15);
        fire(1'b1, 1'b1);
        expect_mix("posclip", 16'h7FFF, 16'h7FFF, 1'b1);

        load(14'h2000, 14'h2000, 8'd0, 4'd15, 4'd15);
        fire(1'b1, 1'b1);
        expect_mix("negclip", 16'h8000, 16'h8000, 1'b1);

        load(14'h0000, 14'h0000, 8'd0, 4'd8, 4'd8);
        fire(1'b1, 1'b1);
        expect_mix("psg_low", 16'hC000, 16'hC000, 1'b0);

        psg_vol = 4'd0;
        fire(1'b0, 1'b1);
        expect_mix("psg_vol0", 16'h0000, 16'h0000, 1'b0);

        load(14'h0800, 14'h3800, 8'd192, 4'd3, 4'd5);
        fire(1'b1, 1'b1);
        expect_mix("gain", 16'h2000, 16'h0800, 1'b0);

        load(14'h3FFF, 14'h0001, 8'd128, 4'd1, 4'd8);
        fire(1'b1, 1'b1);
        expect_mix("floor", 16'hFFFF, 16'h0000, 1'b0);

        mute = 1'b1;
        load(14'h1FFF, 14'h1FFF, 8'd255, 4'd15, 4'd15);
        fire(1'b1, 1'b1);
        expect_mix("mute", 16'h0000, 16'h0000, 1'b0);
        mute = 1'b0;

        // Strobe every other cycle for 20 cycles: commits at c=6,11,16,21,26.
        load(14'h0000, 14'h0000, 8'd128, 4'd8, 4'd8);
        fire(1'b0, 1'b1);
        tick(8);
        last_l = 16'h0;
        for (int c = 0; c < 40; c++) begin
            if (stb === 1'b1) begin
                times.push_back(c);
                last_l = sl;
                $display("commit b2b: cycle %0d L=0x%h R=0x%h", c, sl, sr);
            end
            if (c < 20 && c % 2 == 0) begin
                fm_l = 14'(c * 64 + 64);
                fm_r = 14'(-(c * 64 + 64));
                fm_stb = 1'b1;
            end else begin
                fm_stb = 1'b0;
            end
            tick(1);
        end
        chk("b2b_count", times.size(), 5);
        chk("b2b_first", times.size() > 0 ? times[0] : -1, 6);
        for (int i = 1; i < times.size(); i++)
            chk("b2b_gap", times[i] - times[i-1], 5);
        chk("b2b_last", last_l, 16'h1300);

        load(14'h1000, 14'h3000, 8'd128, 4'd8, 4'd8);
        fire(1'b1, 1'b1);
        tick(2);
        chk("midrst_pre_state", 32'(dut.state_reg), 32'(ST_MUL_FMR));
        rst_n = 1'b0;
        #1;
        chk("midrst_sl", sl, 16'h0);
        chk("midrst_sr", sr, 16'h0);
        chk("midrst_state", 32'(dut.state_reg), 32'(ST_IDLE));
        stb_seen = 0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (stb === 1'b1) stb_seen++;
            tick(1);
        end
        chk("midrst_no_stb", stb_seen, 0);
        chk("midrst_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        $display("reset mid-sequence: %0d strobes seen afterwards", stb_seen);

        fire(1'b1, 1'b1);
        expect_mix("postrst", 16'h4000, 16'hC000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
